// File: rtl/seg7_pkg.sv
// seg7_pkg
// Shared definitions for the 7-segment display path.
//   SEG_0..SEG_9, SEG_BLANK : active-low segment patterns, bit 6 = a ... bit 0 = g.
//                             These are the same encodings the BCD-to-7-segment
//                             driver emits.
//   CODE_BLANK, CODE_ERR    : reconstructed codes for a blank or an illegal pattern.
//   scan_state_e            : dwell tracker states of seg7_scan_decoder.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] CODE_BLANK = 4'hF;
  localparam logic [3:0] CODE_ERR   = 4'hE;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2
  } scan_state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode
// Purely combinational inverse of the BCD-to-7-segment encoder.
// Ports:
//   seg_i  [6:0] : active-low segment pattern, bit 6 = a ... bit 0 = g.
//   code_o [3:0] : 0..9 for a digit, CODE_BLANK for all segments off,
//                  CODE_ERR for anything else.
//   err_o        : high only when the pattern is neither a digit nor blank.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] code_o,
  output logic       err_o
);

  always_comb begin
    code_o = CODE_ERR;
    err_o  = 1'b1;
    case (seg_i)
      SEG_0:     begin code_o = 4'd0;       err_o = 1'b0; end
      SEG_1:     begin code_o = 4'd1;       err_o = 1'b0; end
      SEG_2:     begin code_o = 4'd2;       err_o = 1'b0; end
      SEG_3:     begin code_o = 4'd3;       err_o = 1'b0; end
      SEG_4:     begin code_o = 4'd4;       err_o = 1'b0; end
      SEG_5:     begin code_o = 4'd5;       err_o = 1'b0; end
      SEG_6:     begin code_o = 4'd6;       err_o = 1'b0; end
      SEG_7:     begin code_o = 4'd7;       err_o = 1'b0; end
      SEG_8:     begin code_o = 4'd8;       err_o = 1'b0; end
      SEG_9:     begin code_o = 4'd9;       err_o = 1'b0; end
      SEG_BLANK: begin code_o = CODE_BLANK; err_o = 1'b0; end
      default:   begin code_o = CODE_ERR;   err_o = 1'b1; end
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder
// Snoops a multiplexed, active-low, common-anode display bus and rebuilds the
// code shown on each digit position. A {an, seg} sample must be seen on
// STABLE_CYCLES consecutive edges with exactly one anode low before it is
// captured, which rejects ghosting while the anodes switch.
// Ports:
//   clk, rst            : clock, synchronous active-high reset.
//   seg [6:0]           : segment lines, active-low, seg[6]=a ... seg[0]=g.
//   an  [NUM_DIGITS-1:0]: anode selects, active-low.
//   digits              : captured codes, digit i at [4i+3:4i], 4'hF after reset.
//   digit_valid         : sticky per-position "captured since reset".
//   upd                 : one-cycle pulse per capture.
//   upd_idx             : position of the capture flagged by upd.
//   upd_err             : with upd, the captured pattern was illegal.
//   frame_done          : with upd, every position has now been captured since
//                         the previous frame_done.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter  int unsigned NUM_DIGITS    = 4,
  parameter  int unsigned STABLE_CYCLES = 8,
  localparam int unsigned IDX_W         = $clog2(NUM_DIGITS),
  localparam int unsigned CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg,
  input  logic [NUM_DIGITS-1:0]   an,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    upd,
  output logic [IDX_W-1:0]        upd_idx,
  output logic                    upd_err,
  output logic                    frame_done
);

  localparam int unsigned       REF_W      = NUM_DIGITS + 7;
  localparam logic [CNT_W-1:0]  CNT_TARGET = CNT_W'(STABLE_CYCLES);

  scan_state_e             state_q, state_d;
  logic [REF_W-1:0]        ref_q, ref_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic                    upd_q, upd_d;
  logic [IDX_W-1:0]        upd_idx_q, upd_idx_d;
  logic                    upd_err_q, upd_err_d;
  logic                    frame_q, frame_d;

  logic [REF_W-1:0]        sample;
  logic [NUM_DIGITS-1:0]   sel_mask;
  logic                    sel_ok;
  logic [IDX_W-1:0]        sel_idx;
  logic                    capture;
  logic [3:0]              dec_code;
  logic                    dec_err;

  assign sample   = {an, seg};
  assign sel_mask = ~an;

  // A valid select has exactly one anode low, i.e. sel_mask is one-hot.
  assign sel_ok = (sel_mask != '0) &&
                  ((sel_mask & (sel_mask - NUM_DIGITS'(1))) == '0);

  always_comb begin
    sel_idx = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (sel_mask[i]) sel_idx = IDX_W'(i);
    end
  end

  seg7_pattern_decode u_decode (
    .seg_i  (seg),
    .code_o (dec_code),
    .err_o  (dec_err)
  );

  // Dwell tracker. A capture always happens on an edge where the live inputs
  // equal the tracked pattern, so decode and index come straight from the
  // inputs rather than from ref_q.
  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    if (sample != ref_q) begin
      ref_d = sample;
      cnt_d = CNT_W'(1);
      if (sel_ok) begin
        if (STABLE_CYCLES == 1) begin
          capture = 1'b1;
          state_d = ST_LOCKED;
        end else begin
          state_d = ST_TRACK;
        end
      end else begin
        state_d = ST_IDLE;
      end
    end else if (state_q == ST_TRACK && cnt_q != CNT_TARGET) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_d == CNT_TARGET) begin
        capture = 1'b1;
        state_d = ST_LOCKED;
      end
    end
  end

  // Digit register file, update strobe and frame tracking.
  always_comb begin
    digits_d  = digits_q;
    valid_d   = valid_q;
    seen_d    = seen_q;
    upd_d     = capture;
    upd_idx_d = upd_idx_q;
    upd_err_d = capture & dec_err;
    frame_d   = 1'b0;
    if (capture) begin
      upd_idx_d = sel_idx;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (sel_mask[i]) begin
          digits_d[4*i +: 4] = dec_code;
          valid_d[i]         = 1'b1;
        end
      end
      seen_d = seen_q | sel_mask;
      if (&seen_d) begin
        frame_d = 1'b1;
        seen_d  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ref_q     <= '0;
      cnt_q     <= '0;
      digits_q  <= '1;
      valid_q   <= '0;
      seen_q    <= '0;
      upd_q     <= 1'b0;
      upd_idx_q <= '0;
      upd_err_q <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ref_q     <= ref_d;
      cnt_q     <= cnt_d;
      digits_q  <= digits_d;
      valid_q   <= valid_d;
      seen_q    <= seen_d;
      upd_q     <= upd_d;
      upd_idx_q <= upd_idx_d;
      upd_err_q <= upd_err_d;
      frame_q   <= frame_d;
    end
  end

  assign digits      = digits_q;
  assign digit_valid = valid_q;
  assign upd         = upd_q;
  assign upd_idx     = upd_idx_q;
  assign upd_err     = upd_err_q;
  assign frame_done  = frame_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder
// Scoreboard bench: each stimulus dwell that should produce a capture pushes
// its expected {idx, code, err, frame_done}; every upd pulse pops and compares.
// A second instance built with STABLE_CYCLES=1 covers the immediate-capture case.
module tb_seg7_scan_decoder;

  localparam int unsigned ND = 4;
  localparam int unsigned SC = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [6:0]    seg, seg1;
  logic [ND-1:0] an, an1;
  logic [4*ND-1:0] digits, digits1;
  logic [ND-1:0] dv, dv1;
  logic          upd, upd1;
  logic [1:0]    upd_idx, upd_idx1;
  logic          upd_err, upd_err1;
  logic          fd, fd1;

  int checks   = 0;
  int failures = 0;
  int upd1_count = 0;

  typedef struct {
    int unsigned idx;
    logic [3:0]  code;
    logic        err;
    logic        fd;
  } exp_t;

  exp_t          sb[$];
  logic [ND-1:0] seen_m;
  logic [6:0]    pat[10];

  seg7_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg         (seg),
    .an          (an),
    .digits      (digits),
    .digit_valid (dv),
    .upd         (upd),
    .upd_idx     (upd_idx),
    .upd_err     (upd_err),
    .frame_done  (fd)
  );

  seg7_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(1)) dut1 (
    .clk         (clk),
    .rst         (rst),
    .seg         (seg1),
    .an          (an1),
    .digits      (digits1),
    .digit_valid (dv1),
    .upd         (upd1),
    .upd_idx     (upd_idx1),
    .upd_err     (upd_err1),
    .frame_done  (fd1)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] tb_decode(input logic [6:0] s);
    case (s)
      7'b0000001: return {1'b0, 4'd0};
      7'b1001111: return {1'b0, 4'd1};
      7'b0010010: return {1'b0, 4'd2};
      7'b0000110: return {1'b0, 4'd3};
      7'b1001100: return {1'b0, 4'd4};
      7'b0100100: return {1'b0, 4'd5};
      7'b0100000: return {1'b0, 4'd6};
      7'b0001111: return {1'b0, 4'd7};
      7'b0000000: return {1'b0, 4'd8};
      7'b0000100: return {1'b0, 4'd9};
      7'b1111111: return {1'b0, 4'hF};
      default:    return {1'b1, 4'hE};
    endcase
  endfunction

  function automatic int unsigned zeros_of(input logic [ND-1:0] a);
    int unsigned n = 0;
    for (int i = 0; i < ND; i++) if (!a[i]) n++;
    return n;
  endfunction

  function automatic int unsigned idx_of(input logic [ND-1:0] a);
    int unsigned k = 0;
    for (int i = 0; i < ND; i++) if (!a[i]) k = i;
    return k;
  endfunction

  // Drive a new {an, seg} (caller guarantees it differs from the previous one)
  // and hold it for 'cycles' edges, returning on the negedge after the last.
  task automatic apply(input logic [ND-1:0] a, input logic [6:0] s, input int unsigned cycles);
    logic [4:0] d;
    exp_t       e;
    an  = a;
    seg = s;
    if (zeros_of(a) == 1 && cycles >= SC) begin
      d      = tb_decode(s);
      e.idx  = idx_of(a);
      e.code = d[3:0];
      e.err  = d[4];
      seen_m[e.idx] = 1'b1;
      e.fd   = &seen_m;
      if (e.fd) seen_m = '0;
      sb.push_back(e);
    end
    repeat (cycles) @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (fd) check_eq("fd_needs_upd", {31'd0, upd}, 32'd1);
    if (upd) begin
      if (sb.size() == 0) begin
        check_eq("upd_unexpected", {31'd0, upd}, 32'd0);
      end else begin
        e = sb.pop_front();
        check_eq("sb_idx",  {30'd0, upd_idx}, e.idx);
        check_eq("sb_code", {28'd0, digits[4*upd_idx +: 4]}, {28'd0, e.code});
        check_eq("sb_err",  {31'd0, upd_err}, {31'd0, e.err});
        check_eq("sb_fd",   {31'd0, fd}, {31'd0, e.fd});
      end
    end
  end

  always @(negedge clk) begin
    if (upd1) upd1_count++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [ND-1:0] a;
    pat = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
            7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
    rst = 1'b1; an = '1; seg = '1; an1 = '1; seg1 = '1; seen_m = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_digits",  digits, 32'hFFFF);
    check_eq("rst_valid",   dv, 32'h0);
    check_eq("rst_upd",     upd, 32'h0);
    check_eq("rst_upd_idx", upd_idx, 32'h0);
    check_eq("rst_upd_err", upd_err, 32'h0);
    check_eq("rst_fd",      fd, 32'h0);
    rst = 1'b0;

    // Single digit, exact dwell: upd on the negedge after the 8th edge.
    apply(4'b1110, pat[2], SC);
    check_eq("t1_upd",    upd, 32'd1);
    check_eq("t1_idx",    upd_idx, 32'd0);
    check_eq("t1_digit0", digits[3:0], 32'd2);
    check_eq("t1_valid",  dv, 32'b0001);
    check_eq("t1_err",    upd_err, 32'd0);
    repeat (20) @(negedge clk);

    // Two full scan frames showing 1,2,3,4.
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < ND; i++) begin
        a = ~(4'b0001 << i);
        apply(a, pat[i+1], 10);
      end
    end
    check_eq("t2_digits", digits, 32'h4321);
    check_eq("t2_valid",  dv, 32'hF);

    // Flicker faster than the dwell, then invalid selects.
    for (int k = 0; k < 8; k++) apply(4'b1110, pat[k % 2], 5);
    apply(4'b1100, pat[8], 50);
    apply(4'b1111, pat[8], 50);
    check_eq("t4_digits", digits, 32'h4321);
    check_eq("t4_valid",  dv, 32'hF);

    // Blank on digit 2, illegal pattern on digit 1.
    apply(4'b1011, 7'b1111111, 10);
    apply(4'b1101, 7'b0110110, 10);
    check_eq("t5_digits", digits, 32'h4FE1);

    // Reset lands on the edge that would capture.
    an = 4'b1110; seg = pat[9];
    repeat (SC - 1) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; an = '1; seg = '1; seen_m = '0;
    check_eq("t6_upd",     upd, 32'd0);
    check_eq("t6_digits",  digits, 32'hFFFF);
    check_eq("t6_valid",   dv, 32'h0);
    check_eq("t6_upd_idx", upd_idx, 32'd0);
    check_eq("t6_upd_err", upd_err, 32'd0);
    check_eq("t6_fd",      fd, 32'd0);
    repeat (20) @(negedge clk);

    // Seen mask must restart from reset: frame completes on the fourth capture.
    apply(4'b0111, pat[6], 10);
    apply(4'b1110, pat[3], 10);
    apply(4'b1101, pat[8], 10);
    apply(4'b1011, pat[0], 10);
    check_eq("t6b_digits", digits, 32'h6083);

    // STABLE_CYCLES=1 instance captures on the first edge after a change.
    an1 = 4'b1110; seg1 = pat[7];
    @(negedge clk);
    check_eq("s1_upd",    upd1, 32'd1);
    check_eq("s1_idx",    upd_idx1, 32'd0);
    check_eq("s1_digit0", digits1[3:0], 32'd7);
    check_eq("s1_valid",  dv1, 32'b0001);
    check_eq("s1_err",    upd_err1, 32'd0);
    @(negedge clk);
    check_eq("s1_norepeat", upd1, 32'd0);
    an1 = 4'b1101; seg1 = pat[5];
    @(negedge clk);
    check_eq("s1_upd2",   upd1, 32'd1);
    check_eq("s1_idx2",   upd_idx1, 32'd1);
    check_eq("s1_digit1", digits1[7:4], 32'd5);
    an1 = '1; seg1 = '1;
    repeat (5) @(negedge clk);
    check_eq("s1_count", upd1_count, 32'd2);

    check_eq("sb_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
